// File: rtl/rv32i_mem.sv
// rv32i_mem -- unified byte-addressed instruction/data memory for the rv32i core,
// with a valid/ready program-loader port and a boot sequencer that holds the
// core in reset until loading is complete.
//
// Ports:
//   clk              single clock, rising-edge
//   rst              asynchronous active-low reset (clears FSM, counter and storage)
//   mem_mode         core request: read / write byte / write half / write word
//   mem_address      core byte address (wraps modulo DEPTH)
//   mem_write_value  core store data, low bytes used
//   mem_value        combinational read: bytes A+3..A in bits 31:0
//   cpu_rst          active-high reset for the core (high in BOOT and RELEASE)
//   load_valid       loader beat valid
//   load_ready       high in BOOT only
//   load_addr        loader byte address, bits 1:0 ignored
//   load_data        loader word, little-endian
//   load_done        loader finished; BOOT -> RELEASE
//   reload           RUN -> BOOT, clears load_count
//   load_count       accepted loader beats, saturating at DEPTH/4
module rv32i_mem #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mem_mode,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [31:0]       mem_write_value,
  output logic [31:0]       mem_value,
  output logic              cpu_rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              load_done,
  input  logic              reload,
  output logic [ADDR_W-2:0] load_count
);

  localparam logic [1:0] MEM_READ       = 2'd0;
  localparam logic [1:0] MEM_WRITE_BYTE = 2'd1;
  localparam logic [1:0] MEM_WRITE_HALF = 2'd2;
  localparam logic [1:0] MEM_WRITE_WORD = 2'd3;

  localparam logic [ADDR_W-2:0] LOAD_MAX = (ADDR_W-1)'(DEPTH / 4);

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-2:0] load_count_reg, load_count_next;
  logic              run_active;
  logic              load_accept;

  logic [7:0] mem_q [DEPTH];

  // Word alignment of loader beats makes the low address bits meaningless.
  logic load_addr_unused;
  assign load_addr_unused = ^load_addr[1:0];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_BOOT;
      load_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      load_count_reg <= load_count_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    load_count_next = load_count_reg;
    cpu_rst         = 1'b1;
    load_ready      = 1'b0;
    case (state_reg)
      ST_BOOT: begin
        load_ready = 1'b1;
        if (load_valid && (load_count_reg != LOAD_MAX))
          load_count_next = load_count_reg + 1'b1;
        if (load_done)
          state_next = ST_RELEASE;
      end
      // One full reset cycle for the core with memory already stable.
      ST_RELEASE: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        cpu_rst = 1'b0;
        if (reload) begin
          state_next      = ST_BOOT;
          load_count_next = '0;
        end
      end
      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  assign run_active  = (state_reg == ST_RUN);
  assign load_accept = load_ready && load_valid;
  assign load_count  = load_count_reg;

  // ---------------------------------------------------------------- storage
  // Each byte decides for itself whether it is covered by the current core
  // store (distance from mem_address, modulo DEPTH, below the access size)
  // or by the current loader beat (same word index).
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_byte
      localparam logic [ADDR_W-1:0] BYTE_ADDR = ADDR_W'(gi);

      logic [ADDR_W-1:0] offset;
      logic              core_hit;
      logic              core_we;
      logic              load_we;
      logic [7:0]        core_byte;
      logic [7:0]        load_byte;
      logic [7:0]        byte_reg;

      always_comb begin
        offset   = BYTE_ADDR - mem_address;
        core_hit = 1'b0;
        case (mem_mode)
          MEM_WRITE_BYTE: core_hit = (offset == '0);
          MEM_WRITE_HALF: core_hit = (offset < ADDR_W'(2));
          MEM_WRITE_WORD: core_hit = (offset < ADDR_W'(4));
          default:        core_hit = 1'b0;
        endcase
        core_we   = core_hit && run_active;
        core_byte = mem_write_value[{offset[1:0], 3'b000} +: 8];
        load_we   = load_accept && (load_addr[ADDR_W-1:2] == BYTE_ADDR[ADDR_W-1:2]);
        load_byte = load_data[{BYTE_ADDR[1:0], 3'b000} +: 8];
      end

      // Loader and core writes live in disjoint FSM states, so priority is moot.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          byte_reg <= 8'h00;
        else if (load_we)
          byte_reg <= load_byte;
        else if (core_we)
          byte_reg <= core_byte;
      end

      assign mem_q[gi] = byte_reg;
    end
  endgenerate

  // ---------------------------------------------------------------- read path
  logic [ADDR_W-1:0] rd_a1, rd_a2, rd_a3;
  assign rd_a1 = mem_address + ADDR_W'(1);
  assign rd_a2 = mem_address + ADDR_W'(2);
  assign rd_a3 = mem_address + ADDR_W'(3);

  assign mem_value = {mem_q[rd_a3], mem_q[rd_a2], mem_q[rd_a1], mem_q[mem_address]};

endmodule

// File: tb/tb_rv32i_mem.sv
module tb_rv32i_mem;

  localparam logic [1:0] MEM_READ       = 2'd0;
  localparam logic [1:0] MEM_WRITE_BYTE = 2'd1;
  localparam logic [1:0] MEM_WRITE_HALF = 2'd2;
  localparam logic [1:0] MEM_WRITE_WORD = 2'd3;

  logic        clk;
  logic        rst;
  logic [1:0]  mem_mode;
  logic [7:0]  mem_address;
  logic [31:0] mem_write_value;
  logic [31:0] mem_value;
  logic        cpu_rst;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        load_done;
  logic        reload;
  logic [6:0]  load_count;

  int total_cnt;
  int bad_cnt;

  rv32i_mem #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_mode        (mem_mode),
    .mem_address     (mem_address),
    .mem_write_value (mem_write_value),
    .mem_value       (mem_value),
    .cpu_rst         (cpu_rst),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .load_addr       (load_addr),
    .load_data       (load_data),
    .load_done       (load_done),
    .reload          (reload),
    .load_count      (load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s value=%h", tag, got);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_write(input logic [1:0] mode, input logic [7:0] addr, input logic [31:0] data);
    mem_mode        = mode;
    mem_address     = addr;
    mem_write_value = data;
    tick();
    mem_mode = MEM_READ;
    $display("core write mode=%0d addr=%h data=%h", mode, addr, data);
  endtask

  task automatic load_beat(input logic [7:0] addr, input logic [31:0] data, input logic done);
    load_valid = 1'b1;
    load_addr  = addr;
    load_data  = data;
    load_done  = done;
    tick();
    load_valid = 1'b0;
    load_done  = 1'b0;
    $display("load beat addr=%h data=%h done=%0b", addr, data, done);
  endtask

  task automatic read_check(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    mem_address = addr;
    #1;
    check_value(tag, mem_value, exp);
  endtask

  initial begin
    logic [31:0] or_all;
    total_cnt       = 0;
    bad_cnt         = 0;
    rst             = 1'b0;
    mem_mode        = MEM_READ;
    mem_address     = 8'h00;
    mem_write_value = 32'h0;
    load_valid      = 1'b0;
    load_addr       = 8'h00;
    load_data       = 32'h0;
    load_done       = 1'b0;
    reload          = 1'b0;

    // Reset state
    tick();
    check_value("rst_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    check_value("rst_load_ready", {31'b0, load_ready}, 32'd1);
    check_value("rst_load_count", {25'b0, load_count}, 32'd0);
    read_check("rst_mem0", 8'h00, 32'h0);
    rst = 1'b1;

    // Core half write in BOOT is ignored
    core_write(MEM_WRITE_HALF, 8'h03, 32'h0000CAFE);
    read_check("boot_half_ignored", 8'h00, 32'h0);
    read_check("boot_half_ignored4", 8'h04, 32'h0);

    // Program load, load_done with the second beat
    load_beat(8'h00, 32'h00000013, 1'b0);
    load_beat(8'h04, 32'h12345678, 1'b1);
    check_value("release_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    check_value("release_load_ready", {31'b0, load_ready}, 32'd0);
    tick();
    check_value("run_cpu_rst", {31'b0, cpu_rst}, 32'd0);
    check_value("run_load_count", {25'b0, load_count}, 32'd2);
    read_check("fetch0", 8'h00, 32'h00000013);
    read_check("word4", 8'h04, 32'h12345678);

    // Loader beats in RUN are ignored
    load_beat(8'h08, 32'hFFFFFFFF, 1'b0);
    read_check("run_load_ignored", 8'h08, 32'h0);
    check_value("run_load_count_hold", {25'b0, load_count}, 32'd2);

    // Byte store; pre-write contents visible until the edge
    mem_mode        = MEM_WRITE_BYTE;
    mem_address     = 8'h05;
    mem_write_value = 32'hAABBCCDD;
    #1;
    check_value("byte_prewrite5", mem_value, 32'h00123456);
    tick();
    mem_mode = MEM_READ;
    $display("core write mode=1 addr=05 data=aabbccdd");
    read_check("byte_read4", 8'h04, 32'h1234DD78);
    read_check("byte_read5_unaligned", 8'h05, 32'h001234DD);

    // Half store in RUN
    core_write(MEM_WRITE_HALF, 8'h03, 32'h0000CAFE);
    read_check("half_read0", 8'h00, 32'hFE000013);
    read_check("half_read4", 8'h04, 32'h1234DDCA);

    // Word store wrapping past the top of memory
    core_write(MEM_WRITE_WORD, 8'hFE, 32'hDEADBEEF);
    read_check("wrap_read254", 8'hFE, 32'hDEADBEEF);
    read_check("wrap_read0", 8'h00, 32'hFE00DEAD);
    read_check("wrap_read255", 8'hFF, 32'h00DEADBE);

    // Reload together with a word store: store commits, back to BOOT
    reload = 1'b1;
    core_write(MEM_WRITE_WORD, 8'h10, 32'h01020304);
    reload = 1'b0;
    check_value("reload_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    check_value("reload_load_ready", {31'b0, load_ready}, 32'd1);
    check_value("reload_load_count", {25'b0, load_count}, 32'd0);
    read_check("reload_write16", 8'h10, 32'h01020304);

    // Three beats, then asynchronous reset mid-load
    load_beat(8'h00, 32'h11111111, 1'b0);
    load_beat(8'h05, 32'h22222222, 1'b0);
    load_beat(8'h08, 32'h33333333, 1'b0);
    check_value("boot3_count", {25'b0, load_count}, 32'd3);
    read_check("boot_beat_aligned4", 8'h04, 32'h22222222);
    load_valid = 1'b1;
    load_addr  = 8'h0C;
    load_data  = 32'h44444444;
    #2;
    rst = 1'b0;
    #1;
    check_value("midrst_count", {25'b0, load_count}, 32'd0);
    check_value("midrst_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    or_all = 32'h0;
    for (int a = 0; a < 256; a++) begin
      mem_address = 8'(a);
      #1;
      or_all = or_all | mem_value;
    end
    check_value("midrst_all_clear", or_all, 32'h0);
    tick();
    read_check("midrst_beat_dropped", 8'h0C, 32'h0);
    load_valid = 1'b0;
    rst = 1'b1;

    // 70 beats: count saturates at 64, later beat to same word overwrites
    for (int i = 0; i < 70; i++) begin
      load_beat(8'(i * 4), 32'(i), 1'b0);
    end
    check_value("sat_count", {25'b0, load_count}, 32'd64);
    read_check("sat_last_beat20", 8'h14, 32'd69);
    check_value("sat_still_boot", {31'b0, load_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/rv32i_mem.md
# rv32i_mem

Byte-addressed unified instruction/data memory that answers the rv32i core's memory port (`mem_mode`, `mem_address`, `mem_write_value` in; `mem_value` out). It also provides a valid/ready program-loader port, and holds the core in reset through a boot sequencer until loading completes. It sits between the core and the loader/debug harness in the example top level.

## Interface
- `DEPTH`, 256: storage size in bytes; must equal 2^`ADDR_W`.
- `ADDR_W`, 8: byte-address width; matches the core's `mem_address`.
- `clk`  in  1  single clock; all state updates occur on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `mem_mode`  in  2  core request: `MEM_READ`, `MEM_WRITE_BYTE`, `MEM_WRITE_HALF` or `MEM_WRITE_WORD` (mem_defines.sv).
- `mem_address`  in  `ADDR_W`  core byte address.
- `mem_write_value`  in  32  core store data; the low bytes are used.
- `mem_value`  out  32  read data: bytes at addresses A+3, A+2, A+1, A in bits 31:24, 23:16, 15:8, 7:0.
- `cpu_rst`  out  1  active-high reset that drives the core's `rst`.
- `load_valid`  in  1  loader beat valid.
- `load_ready`  out  1  the memory accepts loader beats.
- `load_addr`  in  `ADDR_W`  loader byte address; bits 1:0 are ignored (word-aligned).
- `load_data`  in  32  loader word, little-endian.
- `load_done`  in  1  loader finished; qualifies the exit from BOOT.
- `reload`  in  1  request to return to BOOT from RUN.
- `load_count`  out  `ADDR_W`-1  number of accepted loader beats, saturating at `DEPTH`/4.

## Operation
- Storage is `DEPTH` bytes. All byte addresses wrap modulo `DEPTH`, e.g. A+3 with A=255 accesses byte 2.
- Read path is combinational from storage, so `mem_value` reflects every write committed at earlier edges. Unaligned reads are legal and return the byte-rotated window starting at A.
- Core writes commit on the edge where `mem_mode` is a write mode and the FSM is in RUN:
  - BYTE writes byte A from bits 7:0.
  - HALF writes bytes A and A+1 from bits 15:0.
  - WORD writes bytes A to A+3 from bits 31:0.
  - All other bytes are unchanged.
- FSM states and transitions:
  - BOOT: `cpu_rst`=1 and `load_ready`=1. Core writes are ignored. A beat with `load_valid`=1 writes 4 bytes at {`load_addr`[7:2],2'b00} and increments `load_count`, saturating. `load_done`=1 moves to RELEASE; a beat in the same cycle is still written.
  - RELEASE: `cpu_rst`=1 and `load_ready`=0. Unconditionally moves to RUN after one cycle, so the core sees a full reset cycle with memory stable.
  - RUN: `cpu_rst`=0 and `load_ready`=0. Core writes are honoured. `reload`=1 moves to BOOT and clears `load_count`. A core write in that same cycle still commits.
- Loader beats outside BOOT are ignored. In BOOT, `load_ready` stays 1 regardless of `load_valid`.

## Timing
- Reset asserted (asynchronous):
  - FSM=BOOT, `cpu_rst`=1, `load_ready`=1, `load_count`=0.
  - All storage bytes are cleared to 0, so `mem_value`=0.
- Reset deassertion takes effect at the first rising edge with `rst`=1.
- Read latency is 0 cycles (combinational). During the cycle a write is presented, `mem_value` shows the pre-write contents; the new value is visible after the edge.
- Core store sequence: the core registers a write mode and address at edge N. Memory commits at edge N+1. The core returns to `MEM_READ` at N+1.
- Loader handshake: one beat is accepted per cycle in which `load_valid` and `load_ready` are both 1; there is no backpressure inside BOOT.
- `load_done` to first core fetch: BOOT→RELEASE at edge E, RELEASE→RUN at E+1. The core leaves reset with `mem_address`=0 and fetches byte 0 from E+2 onward.
- Reset asserted mid-store or mid-load: the write is dropped, storage is cleared, and the FSM returns to BOOT.

## Test plan
- Reset, then load words 0x00000013 @0 and 0x12345678 @4. Assert `load_done` with the second beat. Expect `cpu_rst` to fall exactly 2 edges later; `mem_value`=0x00000013 at `mem_address`=0; `load_count`=2.
- In RUN, `MEM_WRITE_BYTE` 0xAABBCCDD @5 over 0x12345678 @4, then read @4. Expect 0x1234DD78. An unaligned read @5 returns 0x0012_34DD, with byte 8 = 0.
- `MEM_WRITE_WORD` 0xDEADBEEF @254 (wrap). Expect bytes 254=EF, 255=BE, 0=AD, 1=DE. A read @254 returns 0xDEADBEEF.
- `MEM_WRITE_HALF` 0x0000CAFE @3 while in BOOT. Expect no change. The same write after RUN stores bytes 3=FE and 4=CA.
- Assert `reload` in RUN alongside a `MEM_WRITE_WORD`. Expect the write committed, FSM=BOOT, `cpu_rst`=1, `load_count`=0. Loader beats with `load_valid` while in RUN are ignored.
- Drive `rst` low mid-BOOT after 3 beats. Immediately expect `load_count`=0 and `mem_value`=0 at every address. Drive 70 beats and expect `load_count` to saturate at 64.
